// File: rtl/float_from_int.sv
// Integer to packed {sign, exp, man} float encoder, normalising one left shift per cycle.
// Latency 2+leading_zeros cycles (1 for zero); result held in DONE until out_ready.
module float_from_int #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int EXP_BIAS  = 127,
    parameter int INT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [INT_WIDTH-1:0]           in_data,
    input  logic                           in_signed,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   out_data
);

    localparam int EW = EXP_WIDTH + 2;
    localparam int FW = EXP_WIDTH + MAN_WIDTH + 1;
    localparam logic [EW-1:0]        EXP_START = EW'(EXP_BIAS + INT_WIDTH - 1);
    localparam logic [EW-1:0]        EXP_MAX   = {2'b00, {EXP_WIDTH{1'b1}}};
    localparam logic [EW-1:0]        EXP_ONE   = EW'(1);
    localparam logic [INT_WIDTH-1:0] INT_ONE   = INT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t                 state, state_nxt;
    logic                   sign, sign_nxt;
    logic [INT_WIDTH-1:0]   mag, mag_nxt;
    logic [EW-1:0]          exp_acc, exp_nxt;
    logic [FW-1:0]          data_nxt;

    logic [INT_WIDTH-1:0]           in_neg;
    logic                           in_sign;
    logic [INT_WIDTH-1:0]           in_mag;
    logic [INT_WIDTH+MAN_WIDTH-2:0] man_wide;
    logic [MAN_WIDTH-1:0]           man;
    logic                           overflow;

    assign in_neg  = ~in_data + INT_ONE;
    assign in_sign = in_signed & in_data[INT_WIDTH-1];
    assign in_mag  = in_sign ? in_neg : in_data;

    // Appending zeros below the fraction bits covers narrow integers where
    // there are fewer fraction bits than mantissa bits.
    assign man_wide = {mag[INT_WIDTH-2:0], {MAN_WIDTH{1'b0}}};
    assign man      = man_wide[INT_WIDTH+MAN_WIDTH-2 -: MAN_WIDTH];
    assign overflow = (exp_acc >= EXP_MAX);

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign;
        mag_nxt   = mag;
        exp_nxt   = exp_acc;
        data_nxt  = out_data;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_nxt = in_sign;
                    mag_nxt  = in_mag;
                    exp_nxt  = EXP_START;
                    if (in_mag == '0) begin
                        sign_nxt  = 1'b0;
                        data_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                if (!mag[INT_WIDTH-1]) begin
                    mag_nxt = mag << 1;
                    exp_nxt = exp_acc - EXP_ONE;
                end else begin
                    if (overflow) begin
                        data_nxt = {sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                    end else begin
                        data_nxt = {sign, exp_acc[EXP_WIDTH-1:0], man};
                    end
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sign     <= 1'b0;
            mag      <= '0;
            exp_acc  <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            sign     <= sign_nxt;
            mag      <= mag_nxt;
            exp_acc  <= exp_nxt;
            out_data <= data_nxt;
        end
    end

endmodule

// File: tb/tb_float_from_int.sv
// Bench for float_from_int: default-width instance with latency/data scoreboard,
// plus a 5/10-bit float instance for the overflow-to-infinity boundary.
module tb_float_from_int;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_signed, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;

    logic        s_in_valid, s_in_signed, s_out_ready;
    logic [31:0] s_in_data;
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic stall     = 1'b0;
    logic rnd_ready = 1'b0;

    typedef struct {
        logic [31:0] dat;
        int          lat;
        int          acc;
    } exp_t;
    exp_t        q[$];
    logic [15:0] q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_from_int dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    float_from_int #(.EXP_WIDTH(5), .MAN_WIDTH(10), .EXP_BIAS(15), .INT_WIDTH(32)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_signed(s_in_signed),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_f(input logic [31:0] d, input logic s, output int lat);
        logic        neg;
        logic [31:0] m;
        logic [31:0] mn;
        int          p;
        neg = s & d[31];
        m   = neg ? -d : d;
        p   = -1;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        if (p < 0) begin
            lat = 1;
            return 32'h0;
        end
        lat = 33 - p;
        if (p >= 23) mn = (m >> (p - 23)) & 32'h007F_FFFF;
        else         mn = (m << (23 - p)) & 32'h007F_FFFF;
        return {neg, 8'(127 + p), mn[22:0]};
    endfunction

    task automatic send(input logic [31:0] d, input logic s, input logic [31:0] e,
                        input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'h1);
            return;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        if (push) q.push_back('{dat: e, lat: lat, acc: cyc});
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_s(input logic [31:0] d, input logic s, input logic [15:0] e);
        int n = 0;
        @(negedge clk);
        while (!s_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_in_ready) begin
            chk("s_accept_timeout", 32'(s_in_ready), 32'h1);
            return;
        end
        s_in_valid  = 1'b1;
        s_in_data   = d;
        s_in_signed = s;
        q2.push_back(e);
        @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size() + q2.size()), 32'h0);
    endtask

    // Main-instance monitor: latency on the rising cycle, stability while stalled, data on transfer.
    initial begin
        bit          seen = 0;
        bit          prev_xfer = 0;
        logic [31:0] held = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                prev_xfer = 0;
                out_ready = 1'b0;
            end else begin
                if (prev_xfer) chk("one_xfer_per_handshake", 32'(out_valid), 32'h0);
                prev_xfer = 0;
                out_ready = 1'b0;
                if (out_valid) begin
                    chk("in_ready_low_in_done", 32'(in_ready), 32'h0);
                    if (q.size() == 0) begin
                        chk("spurious_valid", 32'(out_valid), 32'h0);
                    end else begin
                        if (!seen) begin
                            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                            held = out_data;
                            seen = 1;
                        end else begin
                            chk("hold_stable", out_data, held);
                        end
                        out_ready = !stall && (!rnd_ready || ($urandom_range(0, 2) != 0));
                        if (out_ready) begin
                            chk("data", out_data, q[0].dat);
                            void'(q.pop_front());
                            seen = 0;
                            prev_xfer = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        s_out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && s_out_valid) begin
                if (q2.size() == 0) chk("s_spurious_valid", 32'(s_out_valid), 32'h0);
                else chk("s_data", 32'(s_out_data), 32'(q2.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] d, e;
        logic        s;
        int          lat;
        int          n;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_s_out_valid", 32'(s_out_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'h1);

        send(32'h0000_0001, 1, 32'h3F80_0000, 33, 1);
        send(32'hFFFF_FFFF, 1, 32'hBF80_0000, 33, 1);
        send(32'h0000_0000, 1, 32'h0000_0000, 1, 1);
        send(32'h0000_0000, 0, 32'h0000_0000, 1, 1);
        send(32'h8000_0000, 0, 32'h4F00_0000, 2, 1);
        send(32'h8000_0000, 1, 32'hCF00_0000, 2, 1);
        send(32'h7FFF_FFFF, 0, 32'h4EFF_FFFF, 3, 1);
        send(32'h00FF_FFFF, 1, 32'h4B7F_FFFF, 10, 1);
        send(32'hFFFF_FFFF, 0, 32'h4F7F_FFFF, 2, 1);
        send(32'hFFFF_FFFE, 1, 32'hC000_0000, 32, 1);
        send(32'h0000_0100, 0, 32'h4380_0000, 25, 1);
        send(32'hFFFF_FF00, 1, 32'hC380_0000, 25, 1);

        send_s(32'd65536, 0, 16'h7C00);
        send_s(32'd65535, 0, 16'h7BFF);
        send_s(32'hFFFF_FFFF, 1, 16'hBC00);
        send_s(32'h0000_0001, 0, 16'h3C00);
        send_s(32'h8000_0000, 1, 16'hFC00);
        drain();

        // Backpressure: result must sit still and a stray in_valid must not be taken.
        stall = 1'b1;
        send(32'h0000_0003, 0, 32'h4040_0000, 32, 1);
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data", out_data, 32'h4040_0000);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            in_valid = (i == 2);
            in_data  = 32'h0000_0005;
        end
        in_valid = 1'b0;
        stall = 1'b0;
        send(32'h0000_0001, 1, 32'h3F80_0000, 33, 1);
        drain();

        // Reset in the middle of normalisation discards the operation.
        send(32'h0000_0001, 1, 32'h0, 0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_valid", 32'(out_valid), 32'h0);
        send(32'h00FF_FFFF, 1, 32'h4B7F_FFFF, 10, 1);
        drain();

        rnd_ready = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) d = -d;
            s = 1'($urandom_range(0, 1));
            e = ref_f(d, s, lat);
            send(d, s, e, lat, 1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
